// File: rtl/spi_arb.sv
// spi_arb: two-requester arbiter in front of a single SPI monarch.
// A winner's command is issued to the monarch. The arbiter then waits for the
// monarch to finish, or aborts after TMO_CYC cycles, and hands the response
// back to the requester that owns the transaction.
//
// state | meaning
// IDLE  | no transaction; arbitrate between req0/req1
// ISSUE | grant pulse plus start strobe to the monarch; timeout counter cleared
// WAIT  | waiting for spi_done; timeout counter running
// CMPL  | done (and err on abort) pulse to the owner; update last-served
module spi_arb #(
  parameter int TMO_CYC = 4096,
  parameter bit RR_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [15:0] cmd0,
  input  logic        req1,
  input  logic [15:0] cmd1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] resp,
  output logic        err,
  output logic        busy,
  output logic        snd,
  output logic [15:0] cmd,
  input  logic        spi_done,
  input  logic [15:0] spi_resp
);

  localparam int CW = $clog2(TMO_CYC) + 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    CMPL  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic          owner;
  logic          last_srv;
  logic          abort_q;
  logic          win;
  logic [CW-1:0] tmo_cnt;

  // Winner selection: a sole requester always wins; a tie goes to the
  // requester not served last (round-robin) or to requester 0 (fixed).
  always_comb begin
    win = 1'b0;
    if (req0 && req1) begin
      win = RR_EN ? ~last_srv : 1'b0;
    end else if (req1) begin
      win = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; a spi_done that coincides with the last timeout cycle
  // still counts as a normal completion.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req0 || req1) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (spi_done || (tmo_cnt == TMO_LAST)) state_nxt = CMPL;
      CMPL:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch command/owner on grant, run the timeout, capture response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner    <= 1'b0;
      last_srv <= 1'b0;
      abort_q  <= 1'b0;
      tmo_cnt  <= '0;
      cmd      <= 16'h0000;
      resp     <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner <= win;
            cmd   <= win ? cmd1 : cmd0;
          end
        end
        ISSUE: begin
          tmo_cnt <= '0;
          abort_q <= 1'b0;
        end
        WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (spi_done) begin
            resp <= spi_resp;
          end else if (tmo_cnt == TMO_LAST) begin
            resp    <= 16'hFFFF;
            abort_q <= 1'b1;
          end
        end
        CMPL: begin
          abort_q  <= 1'b0;
          last_srv <= owner;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state so every pulse lasts exactly one cycle.
  always_comb begin
    gnt0  = (state == ISSUE) && !owner;
    gnt1  = (state == ISSUE) &&  owner;
    snd   = (state == ISSUE);
    done0 = (state == CMPL) && !owner;
    done1 = (state == CMPL) &&  owner;
    err   = (state == CMPL) && abort_q;
    busy  = (state != IDLE);
  end

endmodule
